// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Round-robin arbiter and sequencer sharing one single-port 2**ADDR_W x DATA_W
//   storage array between NREQ requesters. One request is accepted at a time.
//   The access is performed, and a tagged response is returned. A new request
//   can be accepted once every three cycles.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-high reset
//   req_valid  in   NREQ         request pending, one bit per requester
//   req_pkt    in   NREQ*PKT_W   requester i at [i*PKT_W +: PKT_W], packed {addr,data,wr}
//   req_ready  out  NREQ         one-hot accept, asserted only in IDLE
//   rsp_valid  out  1            one-cycle response strobe
//   rsp_id     out  IDW          index of the requester being answered
//   rsp_data   out  DATA_W       read data, or echoed write data
//   busy       out  1            high while an access is in flight
module mem_req_arbiter #(
    parameter  int NREQ   = 4,
    parameter  int ADDR_W = 8,
    parameter  int DATA_W = 8,
    localparam int PKT_W  = ADDR_W + DATA_W + 1,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*PKT_W-1:0] req_pkt,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    gnt_id;
    logic [IDW-1:0]    win_id;
    logic              any_valid;
    logic [PKT_W-1:0]  pkt_arr [NREQ];
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_wr;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            pkt_arr[i] = req_pkt[i*PKT_W +: PKT_W];
        end
    end

    // Winner is the first valid requester found scanning upward from rr_ptr,
    // wrapping at NREQ (which need not be a power of two).
    always_comb begin
        logic [IDW:0] idx;
        win_id    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!any_valid && req_valid[idx[IDW-1:0]]) begin
                any_valid = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any_valid && !rst) begin
                    state_nxt         = ACCESS;
                    req_ready[win_id] = 1'b1;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            result   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt_id                       <= win_id;
                        {lat_addr, lat_data, lat_wr} <= pkt_arr[win_id];
                    end
                end
                ACCESS: begin
                    result <= lat_wr ? lat_data : mem[lat_addr];
                end
                RESP: begin
                    rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    // Storage is never cleared. A reset landing on the ACCESS edge has already
    // forced state to IDLE, so the write is dropped.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && lat_wr) begin
            mem[lat_addr] <= lat_data;
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_id    = gnt_id;
    assign rsp_data  = result;
    assign busy      = (state != IDLE);

endmodule
